// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle MIPS main controller:
//   - FSM state enum and latched instruction-class enum
//   - opcode / funct constants for the supported subset
//   - datapath select encodings (ALUCtrl, nPC_sel, RegDst, MemToReg,
//     ALUSrcA, ALUSrcB, ExtOp)
// -----------------------------------------------------------------------------
package mc_pkg;

    // Controller states
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXE_R   = 4'd2,
        ST_EXE_I   = 4'd3,
        ST_ADDR    = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_MEM_WR  = 4'd6,
        ST_WB_R    = 4'd7,
        ST_WB_I    = 4'd8,
        ST_WB_MEM  = 4'd9,
        ST_BEQ     = 4'd10,
        ST_JAL     = 4'd11,
        ST_JR      = 4'd12,
        ST_ILLEGAL = 4'd13
    } state_e;

    // Instruction class, captured once in DECODE
    typedef enum logic [3:0] {
        CLS_NONE    = 4'd0,
        CLS_ADDU    = 4'd1,
        CLS_SUBU    = 4'd2,
        CLS_ORI     = 4'd3,
        CLS_LUI     = 4'd4,
        CLS_LW      = 4'd5,
        CLS_SW      = 4'd6,
        CLS_BEQ     = 4'd7,
        CLS_JAL     = 4'd8,
        CLS_JR      = 4'd9,
        CLS_ILLEGAL = 4'd10
    } instr_cls_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // ALU operation select
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_IDLE = 3'b111;

    // Next-PC source
    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_ALUOUT = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_REGA   = 2'b11;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_LUI    = 2'b10;
    localparam logic [1:0] M2R_PC     = 2'b11;

    // ALU operand selects
    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_A      = 1'b1;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // Immediate extension mode
    localparam logic EXT_ZERO = 1'b1;
    localparam logic EXT_SIGN = 1'b0;

endpackage : mc_pkg

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Combinational instruction classifier. Maps OPCode/Funct to an instruction
// class; the controller samples the result only while in DECODE.
//
// Ports:
//   OPCode  in  6  IR[31:26]
//   Funct   in  6  IR[5:0]
//   cls     out    instruction class (instr_cls_e)
// -----------------------------------------------------------------------------
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  OPCode,
    input  logic [5:0]  Funct,
    output instr_cls_e  cls
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives cls;
        // a missing assignment on any path would infer a latch.
        cls = CLS_ILLEGAL;
        unique case (OPCode)
            OP_RTYPE: begin
                // R-type is classified purely by Funct; unknown Funct is illegal.
                case (Funct)
                    FN_ADDU: cls = CLS_ADDU;
                    FN_SUBU: cls = CLS_SUBU;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI:  cls = CLS_ORI;
            OP_LUI:  cls = CLS_LUI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule : mc_decode

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle main controller for the MIPS datapath (addu, subu, ori, lw, sw,
// beq, lui, jal, jr). Moore FSM: outputs depend on the current state and the
// instruction class captured in DECODE, plus the memory ready handshake in the
// FETCH and MEM_WR states.
//
// Build option:
//   MC_CTRL_ILLEGAL_HALT_EN  defined   -> ILLEGAL is absorbing, halt=1 until reset
//                            undefined -> ILLEGAL is a one-cycle NOP, halt tied 0
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   OPCode, Funct       instruction fields from IR
//   Zero                ALU zero flag (beq decision)
//   imem_ready          instruction word valid this cycle
//   dmem_ready          data access completes this cycle
//   imem_req, dmem_req  memory requests
//   MemWrite            data access is a write
//   IRWrite, PCWrite    IR / PC load enables
//   nPC_sel             PC source select
//   RegWrite, RegDst,
//   MemToReg            register-file write controls
//   ALUSrcA, ALUSrcB,
//   ExtOp, ALUCtrl      ALU operand/operation controls
//   instr_done          pulse in the final state of each instruction
//   halt                illegal-instruction halt
// -----------------------------------------------------------------------------
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] nPC_sel,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [2:0] ALUCtrl,
    output logic       instr_done,
    output logic       halt
);

    state_e     state_q, state_d;
    instr_cls_e cls_q;
    instr_cls_e dec_cls;

    mc_decode u_decode (
        .OPCode (OPCode),
        .Funct  (Funct),
        .cls    (dec_cls)
    );

    // State register and latched instruction class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_NONE;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            // Capture once; later states must not follow a changing IR.
            if (state_q == ST_DECODE) begin
                cls_q <= dec_cls;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        nPC_sel    = NPC_PC4;
        RegWrite   = 1'b0;
        RegDst     = REGDST_RT;
        MemToReg   = M2R_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ExtOp      = EXT_SIGN;
        ALUCtrl    = ALU_IDLE;
        instr_done = 1'b0;
        halt       = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                // PC+4 is computed every FETCH cycle; it is only committed
                // together with the IR load on the imem_ready cycle. The
                // rst_n gate keeps IR/PC untouched while reset is asserted.
                imem_req = 1'b1;
                ALUSrcA  = SRCA_PC;
                ALUSrcB  = SRCB_FOUR;
                ALUCtrl  = ALU_ADD;
                nPC_sel  = NPC_PC4;
                if (imem_ready && rst_n) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Branch target PC + (sext(imm)<<2) is precomputed into ALUOut.
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_BRANCH;
                ALUCtrl = ALU_ADD;
                case (dec_cls)
                    CLS_ADDU,
                    CLS_SUBU: state_d = ST_EXE_R;
                    CLS_ORI:  state_d = ST_EXE_I;
                    CLS_LUI:  state_d = ST_WB_I;
                    CLS_LW,
                    CLS_SW:   state_d = ST_ADDR;
                    CLS_BEQ:  state_d = ST_BEQ;
                    CLS_JAL:  state_d = ST_JAL;
                    CLS_JR:   state_d = ST_JR;
                    default:  state_d = ST_ILLEGAL;
                endcase
            end

            ST_EXE_R: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_B;
                ALUCtrl = (cls_q == CLS_SUBU) ? ALU_SUB : ALU_ADD;
                state_d = ST_WB_R;
            end

            ST_EXE_I: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ExtOp   = EXT_ZERO;
                ALUCtrl = ALU_OR;
                state_d = ST_WB_I;
            end

            ST_ADDR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ExtOp   = EXT_SIGN;
                ALUCtrl = ALU_ADD;
                state_d = (cls_q == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
            end

            ST_MEM_RD: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = ST_WB_MEM;
                end
            end

            ST_MEM_WR: begin
                // A store has no write-back, so it retires on the ready cycle.
                dmem_req = 1'b1;
                MemWrite = 1'b1;
                if (dmem_ready) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            ST_WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RD;
                MemToReg   = M2R_ALUOUT;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_WB_I: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RT;
                MemToReg   = (cls_q == CLS_LUI) ? M2R_LUI : M2R_ALUOUT;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_WB_MEM: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RT;
                MemToReg   = M2R_MDR;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_BEQ: begin
                // rs - rt; the PC takes the precomputed target only when equal.
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ALUCtrl    = ALU_SUB;
                nPC_sel    = NPC_ALUOUT;
                PCWrite    = Zero;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_JAL: begin
                // $31 gets the already-incremented PC before it is overwritten.
                RegWrite   = 1'b1;
                RegDst     = REGDST_RA;
                MemToReg   = M2R_PC;
                PCWrite    = 1'b1;
                nPC_sel    = NPC_JUMP;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_JR: begin
                PCWrite    = 1'b1;
                nPC_sel    = NPC_REGA;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_ILLEGAL: begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
                // Absorbing: only reset leaves this state.
                halt    = 1'b1;
                state_d = ST_ILLEGAL;
`else
                // Treated as a NOP: retire and fetch the next word.
                instr_done = 1'b1;
                state_d    = ST_FETCH;
`endif
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule : mc_ctrl

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl
// Directed testbench for mc_ctrl. Each scenario task walks an instruction
// cycle by cycle, comparing the full output word against hand-written
// expected vectors. Outputs are sampled 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    // Output bundle, one field per DUT output.
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] npc_sel;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_ctrl;
        logic       instr_done;
        logic       halt;
    } outs_t;

    // One stimulus cycle: inputs plus expected outputs.
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       ir;
        logic       dr;
        outs_t      e;
    } row_t;

    // Hand-derived expected output words per state.
    localparam outs_t E_FETCH_WAIT = '{imem_req:1'b1, alu_src_b:2'b01, alu_ctrl:3'b010, default:'0};
    localparam outs_t E_FETCH_RDY  = '{imem_req:1'b1, ir_write:1'b1, pc_write:1'b1, npc_sel:2'b00,
                                       alu_src_b:2'b01, alu_ctrl:3'b010, default:'0};
    localparam outs_t E_DECODE     = '{alu_src_b:2'b11, alu_ctrl:3'b010, default:'0};
    localparam outs_t E_EXE_ADDU   = '{alu_src_a:1'b1, alu_src_b:2'b00, alu_ctrl:3'b010, default:'0};
    localparam outs_t E_EXE_SUBU   = '{alu_src_a:1'b1, alu_src_b:2'b00, alu_ctrl:3'b011, default:'0};
    localparam outs_t E_EXE_ORI    = '{alu_src_a:1'b1, alu_src_b:2'b10, ext_op:1'b1, alu_ctrl:3'b001, default:'0};
    localparam outs_t E_ADDR       = '{alu_src_a:1'b1, alu_src_b:2'b10, ext_op:1'b0, alu_ctrl:3'b010, default:'0};
    localparam outs_t E_MEM_RD     = '{dmem_req:1'b1, alu_ctrl:3'b111, default:'0};
    localparam outs_t E_MEM_WR     = '{dmem_req:1'b1, mem_write:1'b1, alu_ctrl:3'b111, default:'0};
    localparam outs_t E_MEM_WR_END = '{dmem_req:1'b1, mem_write:1'b1, instr_done:1'b1, alu_ctrl:3'b111, default:'0};
    localparam outs_t E_WB_R       = '{reg_write:1'b1, reg_dst:2'b01, mem_to_reg:2'b00, instr_done:1'b1,
                                       alu_ctrl:3'b111, default:'0};
    localparam outs_t E_WB_ORI     = '{reg_write:1'b1, reg_dst:2'b00, mem_to_reg:2'b00, instr_done:1'b1,
                                       alu_ctrl:3'b111, default:'0};
    localparam outs_t E_WB_LUI     = '{reg_write:1'b1, reg_dst:2'b00, mem_to_reg:2'b10, instr_done:1'b1,
                                       alu_ctrl:3'b111, default:'0};
    localparam outs_t E_WB_MEM     = '{reg_write:1'b1, reg_dst:2'b00, mem_to_reg:2'b01, instr_done:1'b1,
                                       alu_ctrl:3'b111, default:'0};
    localparam outs_t E_BEQ_T      = '{alu_src_a:1'b1, alu_src_b:2'b00, alu_ctrl:3'b011, npc_sel:2'b01,
                                       pc_write:1'b1, instr_done:1'b1, default:'0};
    localparam outs_t E_BEQ_NT     = '{alu_src_a:1'b1, alu_src_b:2'b00, alu_ctrl:3'b011, npc_sel:2'b01,
                                       pc_write:1'b0, instr_done:1'b1, default:'0};
    localparam outs_t E_JAL        = '{reg_write:1'b1, reg_dst:2'b10, mem_to_reg:2'b11, pc_write:1'b1,
                                       npc_sel:2'b10, instr_done:1'b1, alu_ctrl:3'b111, default:'0};
    localparam outs_t E_JR         = '{pc_write:1'b1, npc_sel:2'b11, instr_done:1'b1, alu_ctrl:3'b111, default:'0};
    localparam outs_t E_ILL_NOP    = '{instr_done:1'b1, alu_ctrl:3'b111, default:'0};
    localparam outs_t E_ILL_HALT   = '{halt:1'b1, alu_ctrl:3'b111, default:'0};

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100001;
    localparam logic [5:0] FN_SUB = 6'b100011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_BAD = 6'b001001;

    logic       clk;
    logic       rst_n;
    logic [5:0] OPCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] nPC_sel;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemToReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [2:0] ALUCtrl;
    logic       instr_done;
    logic       halt;

    int vectors;
    int miscompares;

    outs_t obs;
    assign obs = {imem_req, dmem_req, MemWrite, IRWrite, PCWrite, nPC_sel, RegWrite,
                  RegDst, MemToReg, ALUSrcA, ALUSrcB, ExtOp, ALUCtrl, instr_done, halt};

    mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .OPCode     (OPCode),
        .Funct      (Funct),
        .Zero       (Zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .nPC_sel    (nPC_sel),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ExtOp      (ExtOp),
        .ALUCtrl    (ALUCtrl),
        .instr_done (instr_done),
        .halt       (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic row_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input logic ir, input logic dr, input outs_t e);
        row_t r;
        r.op = op; r.fn = fn; r.z = z; r.ir = ir; r.dr = dr; r.e = e;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; OPCode = '0; Funct = '0; Zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        vectors++;
        if (obs !== E_FETCH_WAIT) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", obs, E_FETCH_WAIT);
        end
        imem_ready = 1'b1;
        #1;
        vectors++;
        if (obs !== E_FETCH_WAIT) begin
            miscompares++;
            $display("FAIL reset_imem_ready: got %h expected %h", obs, E_FETCH_WAIT);
        end
        imem_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (obs !== E_FETCH_WAIT) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", obs, E_FETCH_WAIT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_addu();
        row_t rows[$];
        rows.push_back(mk(OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, E_EXE_ADDU));
        rows.push_back(mk(OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, E_WB_R));
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL addu_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Funct flips to addu after DECODE; the latched subu class must hold.
    task automatic test_subu_latched();
        row_t rows[$];
        rows.push_back(mk(OP_R, FN_SUB, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_R, FN_SUB, 1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, E_EXE_SUBU));
        rows.push_back(mk(OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, E_WB_R));
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL subu_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ori_lui();
        row_t rows[$];
        rows.push_back(mk(OP_ORI, 6'h00, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_ORI, 6'h00, 1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_ORI, 6'h00, 1'b0, 1'b1, 1'b0, E_EXE_ORI));
        rows.push_back(mk(OP_ORI, 6'h00, 1'b0, 1'b1, 1'b0, E_WB_ORI));
        rows.push_back(mk(OP_LUI, 6'h00, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_LUI, 6'h00, 1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_LUI, 6'h00, 1'b0, 1'b1, 1'b0, E_WB_LUI));
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL ori_lui_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    // lw with two dmem wait cycles (7 cycles); a stray dmem_ready in ADDR
    // must be ignored.
    task automatic test_lw_wait();
        row_t rows[$];
        rows.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, 1'b1, E_FETCH_RDY));
        rows.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, 1'b1, E_DECODE));
        rows.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, 1'b1, E_ADDR));
        rows.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, 1'b0, E_MEM_RD));
        rows.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, 1'b0, E_MEM_RD));
        rows.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, 1'b1, E_MEM_RD));
        rows.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, 1'b0, E_WB_MEM));
        rows.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, E_FETCH_WAIT));
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL lw_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    // sw behind one imem wait cycle and one dmem wait cycle.
    task automatic test_sw_wait();
        row_t rows[$];
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, E_FETCH_WAIT));
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, E_DECODE));
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, E_ADDR));
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, E_MEM_WR));
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, 1'b1, E_MEM_WR_END));
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0, E_FETCH_WAIT));
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL sw_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        row_t rows[$];
        rows.push_back(mk(OP_BEQ, 6'h00, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_BEQ, 6'h00, 1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_BEQ, 6'h00, 1'b1, 1'b1, 1'b0, E_BEQ_T));
        rows.push_back(mk(OP_BEQ, 6'h00, 1'b1, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_BEQ, 6'h00, 1'b1, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_BEQ, 6'h00, 1'b0, 1'b1, 1'b0, E_BEQ_NT));
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL beq_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal_jr();
        row_t rows[$];
        rows.push_back(mk(OP_JAL, 6'h00, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_JAL, 6'h00, 1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_JAL, 6'h00, 1'b0, 1'b1, 1'b0, E_JAL));
        rows.push_back(mk(OP_R,   FN_JR,  1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_R,   FN_JR,  1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_R,   FN_JR,  1'b0, 1'b1, 1'b0, E_JR));
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL jal_jr_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Illegal opcode, then an R-type with unknown Funct; ends with a reset
    // pulse so later scenarios start from FETCH in either build.
    task automatic test_illegal();
        row_t rows[$];
        rows.push_back(mk(OP_BAD, 6'h00, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_BAD, 6'h00, 1'b0, 1'b1, 1'b0, E_DECODE));
`ifdef MC_CTRL_ILLEGAL_HALT_EN
        rows.push_back(mk(OP_BAD, 6'h00, 1'b0, 1'b1, 1'b1, E_ILL_HALT));
        rows.push_back(mk(OP_BAD, 6'h00, 1'b0, 1'b1, 1'b1, E_ILL_HALT));
        rows.push_back(mk(OP_BAD, 6'h00, 1'b0, 1'b1, 1'b1, E_ILL_HALT));
        rows.push_back(mk(OP_R,   FN_ADD, 1'b0, 1'b1, 1'b0, E_ILL_HALT));
`else
        rows.push_back(mk(OP_BAD, 6'h00, 1'b0, 1'b1, 1'b0, E_ILL_NOP));
        rows.push_back(mk(OP_R,   FN_BAD, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_R,   FN_BAD, 1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_R,   FN_BAD, 1'b0, 1'b1, 1'b0, E_ILL_NOP));
        rows.push_back(mk(OP_R,   FN_BAD, 1'b0, 1'b0, 1'b0, E_FETCH_WAIT));
`endif
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL illegal_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== E_FETCH_WAIT) begin
            miscompares++;
            $display("FAIL illegal_reset: got %h expected %h", obs, E_FETCH_WAIT);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Reset asserted mid-cycle while MEM_WR waits: write strobes must drop
    // immediately, and FETCH resumes after release.
    task automatic test_reset_mid_write();
        row_t rows[$];
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, 1'b0, E_FETCH_RDY));
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, 1'b0, E_DECODE));
        rows.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, 1'b0, E_ADDR));
        foreach (rows[i]) begin
            OPCode = rows[i].op; Funct = rows[i].fn; Zero = rows[i].z;
            imem_ready = rows[i].ir; dmem_ready = rows[i].dr;
            #1;
            vectors++;
            if (obs !== rows[i].e) begin
                miscompares++;
                $display("FAIL rst_wr_c%0d: got %h expected %h", i + 1, obs, rows[i].e);
            end
            @(posedge clk); #1;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        vectors++;
        if (obs !== E_MEM_WR) begin
            miscompares++;
            $display("FAIL rst_wr_in_mem_wr: got %h expected %h", obs, E_MEM_WR);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== E_FETCH_WAIT) begin
            miscompares++;
            $display("FAIL rst_wr_drop: got %h expected %h", obs, E_FETCH_WAIT);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (obs !== E_FETCH_WAIT) begin
            miscompares++;
            $display("FAIL rst_wr_release: got %h expected %h", obs, E_FETCH_WAIT);
        end
        OPCode = OP_R; Funct = FN_ADD; imem_ready = 1'b1;
        #1;
        vectors++;
        if (obs !== E_FETCH_RDY) begin
            miscompares++;
            $display("FAIL rst_wr_fetch: got %h expected %h", obs, E_FETCH_RDY);
        end
        @(posedge clk); #1;
        vectors++;
        if (obs !== E_DECODE) begin
            miscompares++;
            $display("FAIL rst_wr_decode: got %h expected %h", obs, E_DECODE);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_addu();
        test_subu_latched();
        test_ori_lui();
        test_lw_wait();
        test_sw_wait();
        test_beq();
        test_jal_jr();
        test_illegal();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mc_ctrl

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and write-back states for the supported subset: addu, subu, ori, lw, sw, beq, lui, jal, jr. It drives the datapath select and enable lines and handshakes with instruction and data memory. It sits beside the register file, ALU, IR, A/B/ALUOut registers and the PC, and is the only writer of their enables.

## Interface
Parameters:
- none

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- OPCode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access completes this cycle
- imem_req  out  1  instruction read request
- dmem_req  out  1  data access request
- MemWrite  out  1  data access is a write (only with dmem_req)
- IRWrite  out  1  load IR
- PCWrite  out  1  load PC from nPC_sel source
- nPC_sel  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target, 11 register A
- RegWrite  out  1  register file write enable
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemToReg  out  2  00 ALUOut, 01 MDR, 10 imm<<16, 11 PC
- ALUSrcA  out  1  0 PC, 1 A
- ALUSrcB  out  2  00 B, 01 constant 4, 10 ext(imm), 11 sext(imm)<<2
- ExtOp  out  1  1 zero-extend, 0 sign-extend
- ALUCtrl  out  3  001 OR, 010 ADD, 011 SUB, 111 idle
- instr_done  out  1  one-cycle pulse in an instruction's final state
- halt  out  1  illegal-instruction halt (MC_CTRL_ILLEGAL_HALT_EN only; else tied 0)

## Operation
- Moore FSM. Outputs decode from the current state plus the instruction class latched in DECODE. The latched class is not recomputed from live OPCode/Funct.
- States and transitions:
  - FETCH: imem_req=1. Stays in FETCH while imem_ready=0. When imem_ready=1: IRWrite=1; PCWrite=1 with nPC_sel=00, ALUSrcA=0, ALUSrcB=01, ALUCtrl=010; next state DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtrl=010 computes the branch target into ALUOut. Latches the class, then branches:
    - addu/subu → EXE_R
    - ori → EXE_I
    - lui → WB_I
    - lw/sw → ADDR
    - beq → BEQ
    - jal → JAL
    - jr → JR
    - anything else → ILLEGAL
  - EXE_R: ALUSrcA=1, ALUSrcB=00, ALUCtrl 010 (addu) or 011 (subu) → WB_R.
  - EXE_I: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUCtrl=001 → WB_I.
  - ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUCtrl=010 → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: dmem_req=1. Holds until dmem_ready, then → WB_MEM.
  - MEM_WR: dmem_req=1, MemWrite=1. Holds until dmem_ready. The dmem_ready cycle asserts instr_done, then → FETCH.
  - WB_R: RegWrite, RegDst=01, MemToReg=00 → FETCH.
  - WB_I: RegWrite, RegDst=00, MemToReg=00 for ori or 10 for lui → FETCH.
  - WB_MEM: RegWrite, RegDst=00, MemToReg=01 → FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUCtrl=011, nPC_sel=01, PCWrite=Zero → FETCH.
  - JAL: RegWrite, RegDst=10, MemToReg=11; PCWrite, nPC_sel=10 → FETCH.
  - JR: PCWrite, nPC_sel=11 → FETCH.
  - ILLEGAL: see Configuration.
- instr_done is high in each terminal state (WB_*, BEQ, JAL, JR, and MEM_WR on its dmem_ready cycle).
- Any output not listed for a state is 0. ALUCtrl defaults to 111.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH, latched class cleared.
  - Outputs during and immediately after reset: imem_req=1, ALUSrcB=01, ALUCtrl=010; every other output 0.
  - PCWrite and IRWrite stay 0 until imem_ready.
- Reset mid-instruction aborts it with no write. RegWrite, MemWrite and PCWrite drop in the same cycle.
- Latency with zero-wait memory (imem_ready and dmem_ready high on the request cycle):
  - lw: 5 cycles
  - addu, subu, ori, sw: 4 cycles
  - lui, beq, jal, jr: 3 cycles
- Each memory wait cycle adds exactly one cycle. Requests stay asserted and stable until the ready cycle.
- A ready input outside its matching request state is ignored.
- jr with Funct≠001000 and OPCode=0 is not jr: it is classified by Funct, and unknown Funct → ILLEGAL.

## Configuration
- MC_CTRL_ILLEGAL_HALT_EN defined: ILLEGAL is absorbing.
  - halt=1 and all enables are 0 until reset.
- MC_CTRL_ILLEGAL_HALT_EN undefined: ILLEGAL behaves as a NOP.
  - It asserts instr_done for one cycle, then → FETCH.
  - halt is tied 0.

## Structure
- Package mc_pkg holds:
  - state enum
  - opcode and funct constants
  - ALUCtrl, nPC_sel, RegDst, MemToReg and ALUSrcB encodings
  - instruction-class enum
- Sub-module mc_decode: combinational OPCode/Funct → instruction class, used only in DECODE.

## Test plan
- Reset then addu (imem_ready=1 always): states FETCH, DECODE, EXE_R, WB_R; RegWrite=1 with RegDst=01 only in cycle 4; instr_done in cycle 4.
- lw with dmem_ready delayed 2 cycles: MEM_RD held 3 cycles with dmem_req=1; total 7 cycles; MemToReg=01 in WB_MEM.
- beq with Zero=1, then beq with Zero=0: PCWrite=1 with nPC_sel=01 in cycle 3 for the first only; both take 3 cycles.
- jal then jr: jal has RegDst=10, MemToReg=11, PCWrite with nPC_sel=10 in cycle 3; jr has PCWrite with nPC_sel=11 in cycle 3.
- OPCode=6'b111111: with MC_CTRL_ILLEGAL_HALT_EN, halt=1 forever and imem_req=0; without it, instr_done pulses in cycle 3 and FETCH resumes.
- rst_n low during MEM_WR: MemWrite and dmem_req drop in the same cycle; after release, FETCH with imem_req=1.
